// File: rtl/segway_math_pipe.sv
// segway_math_pipe: 3-stage valid-qualified Segway balance math.
// Define SLEW_LIMIT_EN to enable the per-sample output slew limiter.
module segway_math_pipe #(
  parameter int CNTRL_W = 12,
  parameter int SS_W = 8,
  parameter int STEER_W = 12,
  parameter int SPD_W = 12,
  parameter logic [STEER_W-1:0] STEER_MIN = 12'h200,
  parameter logic [STEER_W-1:0] STEER_MAX = 12'hE00,
  parameter int MIN_DUTY = 960,
  parameter int LOW_TORQUE_BAND = 60,
  parameter int GAIN_MULT = 16,
  parameter int FAST_THRESH = 1536,
  parameter int FAST_HYST = 128,
  parameter int FAST_CNT = 4,
  parameter int MAX_STEP = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld_in,
  input  logic [CNTRL_W-1:0] PID_cntrl,
  input  logic [SS_W-1:0]    ss_tmr,
  input  logic [STEER_W-1:0] steer_pot,
  input  logic               en_steer,
  input  logic               pwr_up,
  output logic               vld_out,
  output logic [SPD_W-1:0]   lft_spd,
  output logic [SPD_W-1:0]   rght_spd,
  output logic               too_fast
);

  localparam int PW = CNTRL_W + SS_W + 1;
  localparam int TW = CNTRL_W + 2;
  localparam int XW = TW + 2;
  localparam int CW = $clog2(FAST_CNT + 1);

  localparam logic signed [STEER_W:0] CENTRE =
    (STEER_W+1)'(2**(STEER_W-1) - 1);
  localparam logic signed [XW-1:0] BAND = XW'(LOW_TORQUE_BAND);
  localparam logic signed [XW-1:0] DUTY = XW'(MIN_DUTY);
  localparam logic signed [XW-1:0] GAIN = XW'(GAIN_MULT);
  localparam logic signed [XW-1:0] SPD_MAX = XW'(2**(SPD_W-1) - 1);
  localparam logic signed [XW-1:0] SPD_MIN = XW'(-(2**(SPD_W-1)));
  localparam logic signed [SPD_W-1:0] THR_HI = SPD_W'(FAST_THRESH);
  localparam logic signed [SPD_W-1:0] THR_LO =
    SPD_W'(FAST_THRESH - FAST_HYST);
  localparam logic [CW-1:0] CNT_MAX = CW'(FAST_CNT);

  typedef struct packed {
    logic signed [CNTRL_W-1:0] pid_ss;
    logic signed [STEER_W-1:0] steer;
    logic                      en_steer;
    logic                      pwr_up;
  } s1_t;

  typedef struct packed {
    logic signed [TW-1:0] lt;
    logic signed [TW-1:0] rt;
    logic                 pwr_up;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1_q, v2_q, vo_q;
  logic [SPD_W-1:0] lft_t, rght_t, lft_d, rght_d, lft_q, rght_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic fast, slow, tf_d, tf_q;

  logic signed [PW-1:0] prod, prod_sh;
  logic [STEER_W-1:0] pot_clip;
  logic signed [STEER_W:0] centred;
  logic signed [STEER_W+2:0] steer3, steer_sh;

  function automatic logic [SPD_W-1:0] shape(
    input logic signed [TW-1:0] t
  );
    logic signed [XW-1:0] x, s;
    x = XW'(t);
    if (x >= BAND || x <= -BAND)
      s = x[XW-1] ? x - DUTY : x + DUTY;
    else
      s = x * GAIN;
    if (s > SPD_MAX) s = SPD_MAX;
    else if (s < SPD_MIN) s = SPD_MIN;
    return s[SPD_W-1:0];
  endfunction

`ifdef SLEW_LIMIT_EN
  localparam logic signed [SPD_W:0] STEP = (SPD_W+1)'(MAX_STEP);

  function automatic logic [SPD_W-1:0] slew(
    input logic signed [SPD_W-1:0] tgt,
    input logic signed [SPD_W-1:0] prv
  );
    logic signed [SPD_W:0] d, p;
    p = (SPD_W+1)'(prv);
    d = (SPD_W+1)'(tgt) - p;
    if (d > STEP) d = p + STEP;
    else if (d < -STEP) d = p - STEP;
    else d = (SPD_W+1)'(tgt);
    return d[SPD_W-1:0];
  endfunction
`endif

  always_comb begin
    prod = PW'($signed(PID_cntrl)) * PW'($signed({1'b0, ss_tmr}));
    prod_sh = prod >>> SS_W;
    if (steer_pot < STEER_MIN) pot_clip = STEER_MIN;
    else if (steer_pot > STEER_MAX) pot_clip = STEER_MAX;
    else pot_clip = steer_pot;
    centred = $signed({1'b0, pot_clip}) - CENTRE;
    steer3 = (STEER_W+3)'(centred) + ((STEER_W+3)'(centred) <<< 1);
    steer_sh = steer3 >>> 4;
    s1_d.pid_ss = prod_sh[CNTRL_W-1:0];
    s1_d.steer = steer_sh[STEER_W-1:0];
    s1_d.en_steer = en_steer;
    s1_d.pwr_up = pwr_up;
  end

  always_comb begin
    s2_d.lt = TW'($signed(s1_q.pid_ss));
    s2_d.rt = TW'($signed(s1_q.pid_ss));
    if (s1_q.en_steer) begin
      s2_d.lt = TW'($signed(s1_q.pid_ss)) + TW'($signed(s1_q.steer));
      s2_d.rt = TW'($signed(s1_q.pid_ss)) - TW'($signed(s1_q.steer));
    end
    s2_d.pwr_up = s1_q.pwr_up;
  end

  always_comb begin
    lft_t = s2_q.pwr_up ? shape(s2_q.lt) : '0;
    rght_t = s2_q.pwr_up ? shape(s2_q.rt) : '0;
`ifdef SLEW_LIMIT_EN
    lft_d = slew(lft_t, lft_q);
    rght_d = slew(rght_t, rght_q);
`else
    lft_d = lft_t;
    rght_d = rght_t;
`endif
    fast = ($signed(lft_d) > THR_HI) || ($signed(rght_d) > THR_HI);
    slow = ($signed(lft_d) <= THR_LO) && ($signed(rght_d) <= THR_LO);
    if (!fast) cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else cnt_d = cnt_q + CW'(1);
    // the hysteresis band holds the flag while the run count restarts
    if (cnt_d == CNT_MAX) tf_d = 1'b1;
    else if (slow) tf_d = 1'b0;
    else tf_d = tf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      vo_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      lft_q <= '0;
      rght_q <= '0;
      cnt_q <= '0;
      tf_q <= 1'b0;
    end else begin
      v1_q <= vld_in;
      v2_q <= v1_q;
      vo_q <= v2_q;
      if (vld_in) s1_q <= s1_d;
      if (v1_q) s2_q <= s2_d;
      if (v2_q) begin
        lft_q <= lft_d;
        rght_q <= rght_d;
        cnt_q <= cnt_d;
        tf_q <= tf_d;
      end
    end
  end

  assign vld_out = vo_q;
  assign lft_spd = lft_q;
  assign rght_spd = rght_q;
  assign too_fast = tf_q;

endmodule

// File: tb/tb_segway_math_pipe.sv
// tb_segway_math_pipe: directed and randomized checks of segway_math_pipe
// against a plain-integer reference model.
module tb_segway_math_pipe;

  logic clk;
  logic rst_n;
  logic vld_in;
  logic [11:0] PID_cntrl;
  logic [7:0] ss_tmr;
  logic [11:0] steer_pot;
  logic en_steer;
  logic pwr_up;
  logic vld_out;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic too_fast;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  bit m_tf = 0;
  int m_l = 0;
  int m_r = 0;

  segway_math_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .vld_in(vld_in),
    .PID_cntrl(PID_cntrl),
    .ss_tmr(ss_tmr),
    .steer_pot(steer_pot),
    .en_steer(en_steer),
    .pwr_up(pwr_up),
    .vld_out(vld_out),
    .lft_spd(lft_spd),
    .rght_spd(rght_spd),
    .too_fast(too_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int shape(input int t);
    int s;
    if (t >= 60 || t <= -60) s = (t > 0) ? t + 960 : t - 960;
    else s = t * 16;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  function automatic void exp_spd(input int pid, input int ss,
                                  input int pot, input bit en,
                                  input bit pwr, output int l,
                                  output int r);
    int pss, p, st;
    pss = floor_div(pid * ss, 256);
    p = pot;
    if (p < 'h200) p = 'h200;
    if (p > 'hE00) p = 'hE00;
    st = floor_div((p - 2047) * 3, 16);
    l = en ? pss + st : pss;
    r = en ? pss - st : pss;
    l = pwr ? shape(l) : 0;
    r = pwr ? shape(r) : 0;
  endfunction

  function automatic bit tf_step(input int l, input int r);
    if (l > 1536 || r > 1536) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    else m_cnt = 0;
    if (m_cnt == 4) m_tf = 1;
    else if (l <= 1408 && r <= 1408) m_tf = 0;
    return m_tf;
  endfunction

  function automatic bit out_step(input int l, input int r);
    m_l = l;
    m_r = r;
    return tf_step(l, r);
  endfunction

  task automatic set_in(input int pid, input int ss, input int pot,
                        input bit en, input bit pwr);
    PID_cntrl = pid[11:0];
    ss_tmr = ss[7:0];
    steer_pot = pot[11:0];
    en_steer = en;
    pwr_up = pwr;
  endtask

  task automatic drive(input int pid, input int ss, input int pot,
                       input bit en, input bit pwr);
    set_in(pid, ss, pot, en, pwr);
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
  endtask

  task automatic drive_and_wait(input int pid, input int ss, input int pot,
                                input bit en, input bit pwr);
    drive(pid, ss, pot, en, pwr);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld_in = 1'b0;
    set_in(0, 0, 'h800, 0, 0);
    #1;
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld: got %b want 0", vld_out);
    end
    checks++;
    if (lft_spd !== 12'd0) begin
      errors++;
      $display("FAIL reset_lft: got %0d want 0", lft_spd);
    end
    checks++;
    if (rght_spd !== 12'd0) begin
      errors++;
      $display("FAIL reset_rght: got %0d want 0", rght_spd);
    end
    checks++;
    if (too_fast !== 1'b0) begin
      errors++;
      $display("FAIL reset_tf: got %b want 0", too_fast);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    drive(256, 255, 'h800, 0, 1);
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL lat_clk1: vld_out got %b want 0", vld_out);
    end
    @(negedge clk);
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL lat_clk2: vld_out got %b want 0", vld_out);
    end
    @(negedge clk);
    checks++;
    if (vld_out !== 1'b1) begin
      errors++;
      $display("FAIL lat_clk3: vld_out got %b want 1", vld_out);
    end
    checks++;
    if (lft_spd !== 12'd1215 || rght_spd !== 12'd1215) begin
      errors++;
      $display("FAIL lat_spd: got %0d/%0d want 1215/1215",
               $signed(lft_spd), $signed(rght_spd));
    end
    checks++;
    if (too_fast !== out_step(1215, 1215)) begin
      errors++;
      $display("FAIL lat_tf: got %b want %b", too_fast, m_tf);
    end
    @(negedge clk);
    checks++;
    if (vld_out !== 1'b0 || lft_spd !== 12'd1215) begin
      errors++;
      $display("FAIL lat_hold: vld %b lft %0d want 0 1215",
               vld_out, $signed(lft_spd));
    end
  endtask

  task automatic test_gain();
    int pids[2] = '{32, -32};
    int want[2] = '{496, -512};
    bit tf_e;
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(pids[i], 255, 'h800, 0, 1);
      tf_e = out_step(want[i], want[i]);
      checks++;
      if (vld_out !== 1'b1 || lft_spd !== 12'(want[i]) ||
          rght_spd !== 12'(want[i]) || too_fast !== tf_e) begin
        errors++;
        $display("FAIL gain_%0d: vld %b spd %0d/%0d tf %b want 1 %0d/%0d %b",
                 pids[i], vld_out, $signed(lft_spd), $signed(rght_spd),
                 too_fast, want[i], want[i], tf_e);
      end
    end
  endtask

  task automatic test_steer();
    int pots[3] = '{'hE00, 'hFFF, 'hE00};
    bit ens[3] = '{1'b1, 1'b1, 1'b0};
    int wl[3] = '{1248, 1248, 0};
    int wr[3] = '{-1248, -1248, 0};
    bit tf_e;
    for (int i = 0; i < 3; i++) begin
      drive_and_wait(0, 255, pots[i], ens[i], 1);
      tf_e = out_step(wl[i], wr[i]);
      checks++;
      if (lft_spd !== 12'(wl[i]) || rght_spd !== 12'(wr[i]) ||
          too_fast !== tf_e) begin
        errors++;
        $display("FAIL steer_%0d: spd %0d/%0d tf %b want %0d/%0d %b",
                 i, $signed(lft_spd), $signed(rght_spd), too_fast,
                 wl[i], wr[i], tf_e);
      end
    end
  endtask

  task automatic test_sat();
    bit tf_e;
    drive_and_wait(2047, 255, 'hE00, 1, 1);
    tf_e = out_step(2047, 2047);
    checks++;
    if (lft_spd !== 12'd2047 || rght_spd !== 12'd2047 ||
        too_fast !== tf_e) begin
      errors++;
      $display("FAIL sat: spd %0d/%0d tf %b want 2047/2047 %b",
               $signed(lft_spd), $signed(rght_spd), too_fast, tf_e);
    end
  endtask

  task automatic test_too_fast();
    int idx;
    bit tf_e;
    drive_and_wait(0, 255, 'h800, 0, 1);
    void'(out_step(0, 0));
    checks++;
    if (too_fast !== 1'b0) begin
      errors++;
      $display("FAIL tf_pre: got %b want 0", too_fast);
    end
    for (int c = 0; c < 7; c++) begin
      set_in(1023, 255, 'h800, 0, 1);
      vld_in = (c < 4);
      @(negedge clk);
      if (c >= 2 && c < 6) begin
        idx = c - 2;
        tf_e = (idx == 3);
        void'(out_step(1979, 1979));
        checks++;
        if (vld_out !== 1'b1 || lft_spd !== 12'd1979 ||
            rght_spd !== 12'd1979 || too_fast !== tf_e) begin
          errors++;
          $display("FAIL tf_run_%0d: vld %b spd %0d/%0d tf %b want 1 1979 %b",
                   idx, vld_out, $signed(lft_spd), $signed(rght_spd),
                   too_fast, tf_e);
        end
      end
      if (c == 6) begin
        checks++;
        if (vld_out !== 1'b0) begin
          errors++;
          $display("FAIL tf_run_end: vld_out got %b want 0", vld_out);
        end
      end
    end
    vld_in = 1'b0;
    drive_and_wait(492, 255, 'h800, 0, 1);
    void'(out_step(1450, 1450));
    checks++;
    if (lft_spd !== 12'd1450 || too_fast !== 1'b1) begin
      errors++;
      $display("FAIL tf_band: spd %0d tf %b want 1450 1",
               $signed(lft_spd), too_fast);
    end
    drive_and_wait(0, 255, 'h800, 0, 1);
    void'(out_step(0, 0));
    checks++;
    if (lft_spd !== 12'd0 || too_fast !== 1'b0) begin
      errors++;
      $display("FAIL tf_clear: spd %0d tf %b want 0 0",
               $signed(lft_spd), too_fast);
    end
  endtask

  task automatic test_pwr();
    int idx, wl;
    bit tf_e;
    for (int c = 0; c < 8; c++) begin
      set_in(1023, 255, 'h800, 0, c < 4);
      vld_in = (c < 5);
      @(negedge clk);
      if (c >= 2 && c < 7) begin
        idx = c - 2;
        wl = (idx < 4) ? 1979 : 0;
        tf_e = out_step(wl, wl);
        checks++;
        if (vld_out !== 1'b1 || lft_spd !== 12'(wl) ||
            rght_spd !== 12'(wl) || too_fast !== tf_e) begin
          errors++;
          $display("FAIL pwr_%0d: vld %b spd %0d/%0d tf %b want 1 %0d %b",
                   idx, vld_out, $signed(lft_spd), $signed(rght_spd),
                   too_fast, wl, tf_e);
        end
      end
    end
    vld_in = 1'b0;
  endtask

  task automatic test_random();
    int ql[$];
    int qr[$];
    bit qt[$];
    bit vh[$];
    int hl, hr;
    bit ht;
    hl = m_l;
    hr = m_r;
    ht = m_tf;
    for (int c = 0; c < 300; c++) begin
      bit v, en, pwr, ev;
      int pid, ss, pot, l, r;
      v = (c < 296) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: pid = int'($urandom_range(0, 4095)) - 2048;
        1: pid = int'($urandom_range(950, 1100));
        2: pid = int'($urandom_range(430, 520));
        default: pid = int'($urandom_range(0, 140)) - 70;
      endcase
      ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 255;
      pot = int'($urandom_range(0, 4095));
      en = 1'($urandom_range(0, 1));
      pwr = ($urandom_range(0, 9) != 0);
      set_in(pid, ss, pot, en, pwr);
      vld_in = v;
      if (v) begin
        exp_spd(pid, ss, pot, en, pwr, l, r);
        ql.push_back(l);
        qr.push_back(r);
        qt.push_back(tf_step(l, r));
      end
      vh.push_back(v);
      @(negedge clk);
      if (vh.size() == 3) begin
        ev = vh.pop_front();
        checks++;
        if (vld_out !== ev) begin
          errors++;
          $display("FAIL rnd_vld_c%0d: got %b want %b", c, vld_out, ev);
        end
        if (ev && ql.size() > 0) begin
          hl = ql.pop_front();
          hr = qr.pop_front();
          ht = qt.pop_front();
        end
        checks++;
        if (lft_spd !== 12'(hl) || rght_spd !== 12'(hr) ||
            too_fast !== ht) begin
          errors++;
          $display("FAIL rnd_out_c%0d: spd %0d/%0d tf %b want %0d/%0d %b",
                   c, $signed(lft_spd), $signed(rght_spd), too_fast,
                   hl, hr, ht);
        end
      end
    end
    vld_in = 1'b0;
    m_l = hl;
    m_r = hr;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      set_in(1023, 255, 'h800, 0, 1);
      vld_in = 1'b1;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    vld_in = 1'b0;
    #1;
    checks++;
    if (vld_out !== 1'b0 || lft_spd !== 12'd0 || rght_spd !== 12'd0 ||
        too_fast !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: vld %b spd %0d/%0d tf %b want 0 0/0 0",
               vld_out, $signed(lft_spd), $signed(rght_spd), too_fast);
    end
    m_cnt = 0;
    m_tf = 0;
    m_l = 0;
    m_r = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (vld_out !== 1'b0 || lft_spd !== 12'd0) begin
        errors++;
        $display("FAIL rstmid_flush_%0d: vld %b lft %0d want 0 0",
                 c, vld_out, $signed(lft_spd));
      end
    end
    drive(256, 255, 'h800, 0, 1);
    @(negedge clk);
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_early: vld_out got %b want 0", vld_out);
    end
    @(negedge clk);
    void'(out_step(1215, 1215));
    checks++;
    if (vld_out !== 1'b1 || lft_spd !== 12'd1215 ||
        rght_spd !== 12'd1215) begin
      errors++;
      $display("FAIL rstmid_lat: vld %b spd %0d/%0d want 1 1215/1215",
               vld_out, $signed(lft_spd), $signed(rght_spd));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_gain();
    test_steer();
    test_sat();
    test_too_fast();
    test_pwr();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segway_math_pipe.md
Name: segway_math_pipe

Overview:
- Pipelined, parametrised successor to the combinational Segway balance math.
- Converts the PID controller output, the soft-start timer and the steering pot into signed left/right motor speed commands, with a registered too_fast flag.
- Adds valid-qualified pipelining, saturation, a too_fast persistence/hysteresis filter, and an optional output slew limiter.
- Sits between the PID block and the motor PWM drive.

Parameters:
- CNTRL_W, 12, width of signed PID_cntrl.
- SS_W, 8, width of unsigned ss_tmr; soft-start scale is ss_tmr/2^SS_W.
- STEER_W, 12, width of unsigned steer_pot.
- SPD_W, 12, width of signed speed outputs.
- STEER_MIN, 12'h200, lower clip for steer_pot.
- STEER_MAX, 12'hE00, upper clip for steer_pot.
- MIN_DUTY, 960, dead-band offset added to large torques.
- LOW_TORQUE_BAND, 60, |torque| threshold for dead-band shaping.
- GAIN_MULT, 16, gain applied to small torques.
- FAST_THRESH, 1536, speed above which a sample counts as too fast.
- FAST_HYST, 128, hysteresis below FAST_THRESH required to clear too_fast.
- FAST_CNT, 4, number of consecutive fast samples needed to assert too_fast.
- MAX_STEP, 64, per-sample slew limit (only with SLEW_LIMIT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vld_in  input  1  input sample valid.
- PID_cntrl  input  CNTRL_W  signed PID output.
- ss_tmr  input  SS_W  soft-start scale.
- steer_pot  input  STEER_W  steering potentiometer reading.
- en_steer  input  1  steering enable.
- pwr_up  input  1  rider present / power enable.
- vld_out  output  1  output sample valid.
- lft_spd  output  SPD_W  signed left speed.
- rght_spd  output  SPD_W  signed right speed.
- too_fast  output  1  filtered overspeed flag.

Behaviour:
- Reset (async, rst_n low): all pipeline registers, vld_out, lft_spd, rght_spd, too_fast and the fast counter go to 0 immediately. A reset mid-operation discards in-flight samples.
- Pipeline: 3 stages. Stage registers load only when their valid bit is set. vld_out rises exactly 3 clocks after vld_in. One sample per clock is accepted; there is no backpressure. Outputs hold their last value while vld_out is low.
- Stage 1:
  - PID_ss = (PID_cntrl * {0,ss_tmr}) >>> SS_W, arithmetic shift (floor).
  - steer_pot is clipped to [STEER_MIN, STEER_MAX], then reduced by the centre value 2^(STEER_W-1)-1 to give a signed result.
  - steer = (centred*3) >>> 4.
  - en_steer and pwr_up are registered alongside the sample.
- Stage 2:
  - en_steer = 1: lft_torque = PID_ss + steer; rght_torque = PID_ss - steer.
  - en_steer = 0: both torques equal PID_ss.
  - Width is CNTRL_W+2; no overflow is possible.
- Stage 3, per side:
  - If |torque| >= LOW_TORQUE_BAND: shaped = torque + sign(torque)*MIN_DUTY.
  - Otherwise: shaped = torque*GAIN_MULT.
  - shaped is saturated to [-2^(SPD_W-1), 2^(SPD_W-1)-1].
  - If the pipelined pwr_up is 0, both outputs are forced to 0.
- too_fast, evaluated on each vld_out sample:
  - A sample is fast if lft_spd > FAST_THRESH or rght_spd > FAST_THRESH (signed compare).
  - On a fast sample the counter increments, saturating at FAST_CNT. On a non-fast sample the counter clears.
  - too_fast sets when the counter reaches FAST_CNT, registered on the same edge as that vld_out sample's outputs.
  - too_fast clears only on a valid sample with both speeds <= FAST_THRESH-FAST_HYST.
  - Samples between FAST_THRESH-FAST_HYST and FAST_THRESH hold too_fast and clear the counter.

Optional Feature:
- Macro: SLEW_LIMIT_EN.
- Defined: after saturation and pwr_up forcing, each output moves at most MAX_STEP from its previous registered value per valid sample. The pwr_up=0 forcing also ramps toward 0. too_fast uses the slewed values.
- Undefined: outputs update directly to the saturated values.

Test Plan:
- Latency and scale:
  - Stimulus: vld_in pulse with PID_cntrl=256, ss_tmr=255, en_steer=0, pwr_up=1.
  - Response: vld_out exactly 3 clocks later; lft_spd=rght_spd=1215; too_fast=0.
- Small-torque gain:
  - PID_cntrl=32, ss_tmr=255 -> both speeds 496.
  - PID_cntrl=-32 -> both speeds -512 (floor of -31.875 is -32).
- Steering and clip:
  - PID_cntrl=0, en_steer=1, steer_pot=12'hE00 -> lft=1248, rght=-1248.
  - steer_pot=12'hFFF -> same values (clipped).
  - en_steer=0 -> both speeds 0.
- Saturation:
  - PID_cntrl=2047, ss_tmr=255, steer_pot=12'hE00, en_steer=1 -> lft_spd=2047 (saturated), rght_spd=2039-288+960=2711 -> saturated 2047.
- too_fast filter:
  - Stream PID_cntrl=1023, ss_tmr=255 -> speeds 1979; too_fast asserts on the 4th consecutive valid output, not on the 3rd.
  - Then a sample at speed 1450 -> too_fast holds.
  - Then PID_cntrl=0 -> speed 0; too_fast clears.
- pwr_up and reset:
  - pwr_up=0 with PID_cntrl=1023 -> outputs 0 three clocks later; too_fast clears.
  - rst_n low mid-stream -> all outputs 0 asynchronously; no vld_out until 3 clocks after the next vld_in.
